// File: rtl/i2c_temp_reader.sv
// i2c_temp_reader: I2C master that polls the ADT7420 16-bit temperature register.
// Optional one-shot configuration write (16-bit resolution) when I2C_CFG_WRITE_EN is defined.
module i2c_temp_reader #(
    parameter int         CLK_FREQ_HZ = 100_000_000,
    parameter int         SCL_FREQ_HZ = 100_000,
    parameter logic [6:0] DEV_ADDR    = 7'h4B,
    parameter int         POLL_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        scl,
    inout  wire         sda,
    output logic [15:0] dis_data,
    output logic        data_valid,
    output logic        busy,
    output logic        ack_err
);

    localparam int QDIV = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(QDIV - 1);
    localparam logic [PW-1:0] P_LAST = PW'(POLL_CYCLES - 1);

    typedef enum logic [4:0] {
        IDLE, START, ADDR_W, ACK1, PTR, ACK2, RSTART, ADDR_R, ACK3,
        RD_MSB, MACK, RD_LSB, MNACK, CFG_DATA, ACK4, STOP, DONE
    } state_t;

    state_t          state;
    state_t          ns;
    logic [1:0]      phase;
    logic [QW-1:0]   qcnt;
    logic [PW-1:0]   poll_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      tx;
    logic [7:0]      ntx;
    logic [7:0]      rx;
    logic [7:0]      msb;
    logic            nack;
    logic            sda_oe;
    logic            sda_in;
    logic            cfg_txn;
    logic            qtick;
    logic            poll_wrap;

    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign sda_in    = sda;
    assign qtick     = (qcnt == Q_LAST);
    assign poll_wrap = (poll_cnt == P_LAST);

`ifdef I2C_CFG_WRITE_EN
    logic cfg_done;
`else
    assign cfg_txn = 1'b0;
`endif

    // {scl, sda_oe} for a given slot type and quarter phase
    function automatic logic [1:0] slot_out(state_t s, logic [1:0] ph, logic b);
        case (s)
            IDLE, DONE:                      return 2'b10;
            START:                           return {1'b1, ph[1]};
            RSTART:                          return {ph[1], ph == 2'd3};
            STOP:                            return {ph[1], ph != 2'd3};
            ADDR_W, PTR, ADDR_R, CFG_DATA:   return {ph[1], ~b};
            MACK:                            return {ph[1], 1'b1};
            default:                         return {ph[1], 1'b0};
        endcase
    endfunction

    always_comb begin
        ns = state;
        case (state)
            START:    ns = nack ? STOP : ADDR_W;
            ADDR_W:   if (bit_cnt == 3'd7) ns = ACK1;
            ACK1:     ns = nack ? STOP : PTR;
            PTR:      if (bit_cnt == 3'd7) ns = ACK2;
            ACK2:     ns = nack ? STOP : (cfg_txn ? CFG_DATA : RSTART);
            RSTART:   ns = ADDR_R;
            ADDR_R:   if (bit_cnt == 3'd7) ns = ACK3;
            ACK3:     ns = nack ? STOP : RD_MSB;
            RD_MSB:   if (bit_cnt == 3'd7) ns = MACK;
            MACK:     ns = RD_LSB;
            RD_LSB:   if (bit_cnt == 3'd7) ns = MNACK;
            MNACK:    ns = STOP;
            CFG_DATA: if (bit_cnt == 3'd7) ns = ACK4;
            ACK4:     ns = STOP;
            STOP:     ns = DONE;
            default:  ns = state;
        endcase
    end

    always_comb begin
        ntx = {tx[6:0], 1'b0};
        if (ns != state) begin
            case (ns)
                ADDR_W:   ntx = {DEV_ADDR, 1'b0};
                PTR:      ntx = cfg_txn ? 8'h03 : 8'h00;
                ADDR_R:   ntx = {DEV_ADDR, 1'b1};
                CFG_DATA: ntx = 8'h80;
                default:  ntx = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        data_valid <= 1'b0;
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            qcnt     <= '0;
            poll_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= '0;
            rx       <= '0;
            msb      <= '0;
            nack     <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            dis_data <= '0;
            busy     <= 1'b0;
            ack_err  <= 1'b0;
`ifdef I2C_CFG_WRITE_EN
            cfg_txn  <= 1'b0;
            cfg_done <= 1'b0;
`endif
        end else begin
            poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
            case (state)
                IDLE: begin
                    qcnt    <= '0;
                    phase   <= '0;
                    bit_cnt <= '0;
                    nack    <= 1'b0;
                    if (poll_wrap) begin
                        state           <= START;
                        busy            <= 1'b1;
                        {scl, sda_oe}   <= slot_out(START, 2'd0, 1'b0);
`ifdef I2C_CFG_WRITE_EN
                        cfg_txn         <= !cfg_done;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (nack) begin
                        ack_err <= 1'b1;
                    end else if (!cfg_txn) begin
                        dis_data   <= {msb, rx};
                        data_valid <= 1'b1;
                        ack_err    <= 1'b0;
                    end
`ifdef I2C_CFG_WRITE_EN
                    else begin
                        cfg_done <= 1'b1;
                    end
`endif
                end
                default: begin
                    qcnt <= qtick ? '0 : qcnt + 1'b1;
                    if (qtick) begin
                        // A bus already held low before START is treated like a NACK.
                        if (state == START && phase == 2'd1 && !sda_in)
                            nack <= 1'b1;
                        if (phase == 2'd2) begin
                            if ((state == ACK1 || state == ACK2 || state == ACK3 ||
                                 state == ACK4) && sda_in)
                                nack <= 1'b1;
                            if (state == RD_MSB || state == RD_LSB)
                                rx <= {rx[6:0], sda_in};
                        end
                        if (phase == 2'd3) begin
                            state         <= ns;
                            phase         <= '0;
                            tx            <= ntx;
                            bit_cnt       <= (ns == state) ? bit_cnt + 3'd1 : 3'd0;
                            {scl, sda_oe} <= slot_out(ns, 2'd0, ntx[7]);
                            if (state == RD_MSB && ns != state)
                                msb <= rx;
                        end else begin
                            phase         <= phase + 2'd1;
                            {scl, sda_oe} <= slot_out(state, phase + 2'd1, tx[7]);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_temp_reader.sv
// tb_i2c_temp_reader: directed/randomized bench with a behavioural ADT7420 slave,
// a bus monitor and a frame-level reference model of each transaction.
`timescale 1ns/1ps
module tb_i2c_temp_reader;

    localparam int         QDIV = 4;
    localparam int         POLL = 1200;
    localparam int         SLOT = 4 * QDIV;
    localparam logic [6:0] DEV  = 7'h4B;
    localparam int K_READ = 0, K_NACK = 1, K_STUCK = 2, K_CFG = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl, data_valid, busy, ack_err;
    logic [15:0] dis_data;
    tri1         sda;

    logic        stuck = 1'b0;
    logic        nack_addr = 1'b0;
    logic        drv = 1'b0;
    logic [15:0] rdata = 16'h0C80;

    assign sda = (stuck || drv) ? 1'b0 : 1'bz;

    i2c_temp_reader #(
        .CLK_FREQ_HZ(1_600_000),
        .SCL_FREQ_HZ(100_000),
        .DEV_ADDR(DEV),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scl(scl),
        .sda(sda),
        .dis_data(dis_data),
        .data_valid(data_valid),
        .busy(busy),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    int since_rst = 0;
    always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

    // bus monitor and slave: frames are 8 data bits + ack, logged per byte
    logic       p_scl = 1'b1, p_sda = 1'b1, in_read = 1'b0;
    int         fb = 0, frame = 0, rd_idx = 0, starts = 0, stops = 0, nlog = 0;
    logic [7:0] shreg = '0;
    logic [7:0] log_byte [256];
    logic       log_ack  [256];

    always @(negedge clk) begin
        p_scl <= scl;
        p_sda <= sda;
        if (p_scl && scl && p_sda && !sda) begin
            starts <= starts + 1; fb <= 0; frame <= 0; in_read <= 1'b0; drv <= 1'b0;
        end else if (p_scl && scl && !p_sda && sda) begin
            stops <= stops + 1; fb <= 0; frame <= 0; in_read <= 1'b0; drv <= 1'b0;
        end else if (!p_scl && scl) begin
            if (fb == 8) begin
                if (nlog < 256) begin
                    log_byte[nlog] <= shreg;
                    log_ack[nlog]  <= sda;
                    nlog <= nlog + 1;
                end
                fb <= 0;
                frame <= frame + 1;
                if (frame == 0 && shreg[0] && !sda) begin
                    in_read <= 1'b1; rd_idx <= 0;
                end else if (in_read) begin
                    rd_idx <= rd_idx + 1;
                end
            end else begin
                shreg <= {shreg[6:0], sda};
                fb <= fb + 1;
            end
        end else if (p_scl && !scl) begin
            if (fb == 8) drv <= !in_read && !(frame == 0 && nack_addr);
            else         drv <= in_read && rd_idx < 2 && !rdata[15 - 8*rd_idx - fb];
        end
    end

    int tests = 0, fails = 0;
    logic [15:0] model_dis = '0;
    logic        model_err = 1'b0;
    logic [7:0]  exp_b [$];
    logic        exp_a [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_scl"}, scl, 1);
        check({tag, "_sda"}, sda, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dis"}, dis_data, 0);
        check({tag, "_dv"}, data_valid, 0);
        check({tag, "_err"}, ack_err, 0);
    endtask

    task automatic wait_busy(input string tag, output int t0);
        int n;
        n = 0;
        while (!busy && n < 3 * POLL) begin @(negedge clk); n++; end
        check({tag, "_busy_rise"}, busy, 1);
        t0 = since_rst;
    endtask

    // Model: frames, slot count and outcome derived from the protocol only.
    task automatic txn(input string tag, input int kind, input int exp_start);
        int t0, t1, ndv, tdv, base, st0, sp0, slots, n, e_dv;
        exp_b.delete(); exp_a.delete();
        case (kind)
            K_READ: begin
                exp_b = '{{DEV, 1'b0}, 8'h00, {DEV, 1'b1}, rdata[15:8], rdata[7:0]};
                exp_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            end
            K_NACK: begin exp_b = '{{DEV, 1'b0}}; exp_a = '{1'b1}; end
            K_CFG: begin
                exp_b = '{{DEV, 1'b0}, 8'h03, 8'h80};
                exp_a = '{1'b0, 1'b0, 1'b0};
            end
            default: ;
        endcase
        slots = 2 + 9 * exp_b.size() + ((kind == K_READ) ? 1 : 0);
        base = nlog; st0 = starts; sp0 = stops;
        ndv = 0; tdv = -1;
        wait_busy(tag, t0);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk); n++;
            if (data_valid) begin ndv++; tdv = since_rst; end
        end
        check({tag, "_busy_fall"}, busy, 0);
        t1 = since_rst;
        @(negedge clk);
        if (data_valid) ndv++;
        if (kind == K_READ) begin
            model_dis = rdata; model_err = 1'b0;
        end else if (kind != K_CFG) begin
            model_err = 1'b1;
        end
        check({tag, "_start"}, t0, exp_start);
        check({tag, "_busy_len"}, t1 - t0, slots * SLOT + 1);
        check({tag, "_dv_count"}, ndv, (kind == K_READ) ? 1 : 0);
        if (kind == K_READ) begin
            e_dv = t0 + slots * SLOT + 1;
            check({tag, "_dv_time"}, (tdv >= e_dv - 2 && tdv <= e_dv + 2), 1);
        end
        check({tag, "_dis"}, dis_data, model_dis);
        check({tag, "_err"}, ack_err, model_err);
        if (kind != K_STUCK) begin
            check({tag, "_nbytes"}, nlog - base, exp_b.size());
            for (int i = 0; i < exp_b.size(); i++) begin
                check($sformatf("%s_byte%0d", tag, i), log_byte[base + i], exp_b[i]);
                check($sformatf("%s_ack%0d", tag, i), log_ack[base + i], exp_a[i]);
            end
            check({tag, "_starts"}, starts - st0, (kind == K_READ) ? 2 : 1);
            check({tag, "_stops"}, stops - sp0, 1);
        end
    endtask

    initial begin
        int t;
        int next_start;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        next_start = POLL;
`ifdef I2C_CFG_WRITE_EN
        txn("cfg0", K_CFG, next_start); next_start += POLL;
`endif
        rdata = 16'h0C80;
        txn("read1", K_READ, next_start); next_start += POLL;
        check("read1_degC", dis_data[14:7], 8'd25);

        nack_addr = 1'b1;
        txn("nack", K_NACK, next_start); next_start += POLL;
        nack_addr = 1'b0;

        rdata = 16'($urandom);
        txn("read2", K_READ, next_start); next_start += POLL;

        // reset in the middle of slot 20 of a read
        rdata = 16'($urandom);
        wait_busy("rst_mid", t);
        check("rst_mid_start", t, next_start);
        repeat (20 * SLOT + SLOT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_mid");
        rst = 1'b0;
        model_dis = '0; model_err = 1'b0;
        next_start = POLL;
`ifdef I2C_CFG_WRITE_EN
        txn("cfg1", K_CFG, next_start); next_start += POLL;
`endif
        rdata = 16'($urandom);
        txn("read3", K_READ, next_start); next_start += POLL;

        stuck = 1'b1;
        txn("stuck1", K_STUCK, next_start); next_start += POLL;
        txn("stuck2", K_STUCK, next_start); next_start += POLL;
        stuck = 1'b0;
        repeat (4) @(negedge clk);

        rdata = 16'($urandom);
        txn("read4", K_READ, next_start);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
